ofdm_frame_sched: RTL and testbench

Frame scheduler for the OFDM transmit chain. Per frame it walks N_PRE preamble symbols then N_DATA data symbols, one subcarrier slot per handshake. For every slot it tells the mapper what belongs there: null, preamble, pilot or QAM data. It pops the QAM and pilot sources exactly once per DATA/PILOT slot, so upstream ROM/QAM and pilot blocks are sequenced by one controller instead of ad-hoc ready chains.

---
 rtl/ofdm_frame_sched.sv | 146 ++++++++++++++
 tb/tb_ofdm_frame_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_sched.sv
`timescale 1ns/1ps
// OFDM frame scheduler: walks preamble then data symbols, tags each subcarrier slot and pops QAM/pilot sources.
// Latency: sop one cycle after start; backpressure: slot and all outputs hold while ready_in is low.
module ofdm_frame_sched #(
    parameter int N_FFT      = 2048,
    parameter int GUARD_LO   = 100,
    parameter int GUARD_HI   = 100,
    parameter int PILOT_STEP = 12,
    parameter int N_PRE      = 1,
    parameter int N_DATA     = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     en,
    input  logic                     start,
    input  logic                     ready_in,
    input  logic                     data_valid,
    output logic                     valid_out,
    output logic [1:0]               sel,
    output logic [$clog2(N_FFT)-1:0] count,
    output logic [7:0]               sym,
    output logic                     pilot_sign,
    output logic                     data_req,
    output logic                     pilot_req,
    output logic                     sop,
    output logic                     eos,
    output logic                     eof,
    output logic                     busy
);

    localparam int CW = $clog2(N_FFT);
    localparam int PW = (PILOT_STEP > 1) ? $clog2(PILOT_STEP) : 1;

    localparam logic [CW-1:0] K_LAST   = CW'(N_FFT - 1);
    localparam logic [CW-1:0] K_DC     = CW'(N_FFT / 2);
    localparam logic [CW-1:0] K_HI     = CW'(N_FFT - 1 - GUARD_HI);
    localparam logic [CW-1:0] K_LO     = CW'(GUARD_LO);
    localparam logic [PW-1:0] PH_LAST  = PW'(PILOT_STEP - 1);
    localparam logic [7:0]    PRE_LAST = 8'(N_PRE - 1);
    localparam logic [7:0]    SYM_LAST = 8'(N_PRE + N_DATA - 1);

    localparam logic [1:0] SEL_NULL   = 2'd0;
    localparam logic [1:0] SEL_PREAMB = 2'd1;
    localparam logic [1:0] SEL_PILOT  = 2'd2;
    localparam logic [1:0] SEL_DATA   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [6:0]    lfsr;
    logic [PW-1:0] phase;
    logic          accept;
    logic          last_slot;
    logic          last_frame;
    logic          null_slot;

    assign accept     = valid_out & ready_in;
    assign last_slot  = (count == K_LAST);
    assign last_frame = last_slot & (sym == SYM_LAST);
    assign null_slot  = (count < K_LO) | (count > K_HI) | (count == K_DC);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= S_IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PRE;
            S_PRE:   if (accept && last_slot && sym == PRE_LAST) state_nxt = S_BODY;
            S_BODY:  if (accept && last_frame) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase tracks (count - GUARD_LO) mod PILOT_STEP for the slot on display, so no divider is needed.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            count <= '0;
            sym   <= '0;
            lfsr  <= 7'h7F;
            phase <= '0;
        end else if (en) begin
            if (state == S_IDLE) begin
                if (start) begin
                    count <= '0;
                    sym   <= '0;
                    lfsr  <= 7'h7F;
                    phase <= '0;
                end
            end else if (accept) begin
                if (last_slot) begin
                    count <= '0;
                    phase <= '0;
                    sym   <= last_frame ? 8'd0 : sym + 8'd1;
                    if (state == S_BODY) begin
                        lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
                    end
                end else begin
                    count <= count + CW'(1);
                    if (count < K_LO || phase == PH_LAST) begin
                        phase <= '0;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        sel = SEL_NULL;
        case (state)
            S_PRE: sel = SEL_PREAMB;
            S_BODY: begin
                if (null_slot) begin
                    sel = SEL_NULL;
                end else if (phase == '0) begin
                    sel = SEL_PILOT;
                end else begin
                    sel = SEL_DATA;
                end
            end
            default: sel = SEL_NULL;
        endcase
        busy       = (state != S_IDLE);
        // Only DATA slots wait on the QAM source; everything else flows regardless.
        valid_out  = en & busy & ((sel != SEL_DATA) | data_valid);
        data_req   = valid_out & ready_in & (sel == SEL_DATA);
        pilot_req  = valid_out & ready_in & (sel == SEL_PILOT);
        sop        = valid_out & (sym == 8'd0) & (count == '0);
        eos        = valid_out & last_slot;
        eof        = valid_out & last_frame;
        pilot_sign = busy & lfsr[6];
    end

endmodule

// File: tb/tb_ofdm_frame_sched.sv
`timescale 1ns/1ps
// Randomised bench for ofdm_frame_sched: a slot-level model checks every cycle, literals pin the model.
module tb_ofdm_frame_sched;

    localparam int N_FFT = 16;
    localparam int GLO   = 2;
    localparam int GHI   = 1;
    localparam int STEP  = 4;
    localparam int NPRE  = 1;

    logic clk = 1'b0;
    logic res, en, start, start_long, ready_in, data_valid;

    logic       valid_out, pilot_sign, data_req, pilot_req, sop, eos, eof, busy;
    logic [1:0] sel;
    logic [3:0] count;
    logic [7:0] sym;

    logic       valid_out_l, pilot_sign_l, data_req_l, pilot_req_l, sop_l, eos_l, eof_l, busy_l;
    logic [1:0] sel_l;
    logic [3:0] count_l;
    logic [7:0] sym_l;

    ofdm_frame_sched #(.N_FFT(N_FFT), .GUARD_LO(GLO), .GUARD_HI(GHI), .PILOT_STEP(STEP),
                       .N_PRE(NPRE), .N_DATA(2)) dut (
        .clk(clk), .res(res), .en(en), .start(start), .ready_in(ready_in),
        .data_valid(data_valid), .valid_out(valid_out), .sel(sel), .count(count),
        .sym(sym), .pilot_sign(pilot_sign), .data_req(data_req), .pilot_req(pilot_req),
        .sop(sop), .eos(eos), .eof(eof), .busy(busy)
    );

    ofdm_frame_sched #(.N_FFT(N_FFT), .GUARD_LO(GLO), .GUARD_HI(GHI), .PILOT_STEP(STEP),
                       .N_PRE(NPRE), .N_DATA(255)) dut_long (
        .clk(clk), .res(res), .en(en), .start(start_long), .ready_in(ready_in),
        .data_valid(data_valid), .valid_out(valid_out_l), .sel(sel_l), .count(count_l),
        .sym(sym_l), .pilot_sign(pilot_sign_l), .data_req(data_req_l), .pilot_req(pilot_req_l),
        .sop(sop_l), .eos(eos_l), .eof(eof_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state per instance: 0 = short frame, 1 = 255-data-symbol frame
    int m_busy [2];
    int m_sym  [2];
    int m_k    [2];
    int acc_cnt[2];
    int dreq_cnt[2];
    int preq_cnt[2];
    int frames [2];
    bit prev_stall[2];
    logic [21:0] prev_vec[2];

    logic [21:0] act0, act1, av, ev;
    bit st;
    int nd;

    logic [1:0] lit_body [16] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3,
                                  2'd0, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0};
    bit lit_sign [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    assign act0 = {valid_out, sel, count, sym, pilot_sign, data_req, pilot_req, sop, eos, eof, busy};
    assign act1 = {valid_out_l, sel_l, count_l, sym_l, pilot_sign_l, data_req_l, pilot_req_l,
                   sop_l, eos_l, eof_l, busy_l};

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int sel_of(int s, int k);
        if (s < NPRE) return 1;
        if (k < GLO || k > N_FFT - 1 - GHI || k == N_FFT / 2) return 0;
        if ((k - GLO) % STEP == 0) return 2;
        return 3;
    endfunction

    function automatic bit sign_of(int s);
        logic [6:0] l;
        l = 7'h7F;
        for (int j = 0; j < s - NPRE; j++) l = {l[5:0], l[6] ^ l[3]};
        return l[6];
    endfunction

    function automatic logic [21:0] model_out(int i, bit e, bit dv, bit rdy);
        logic [21:0] r;
        logic [1:0]  sl;
        bit b, v, a;
        int s, k, n;
        b  = (m_busy[i] != 0);
        s  = m_sym[i];
        k  = m_k[i];
        n  = (i == 0) ? 2 : 255;
        sl = b ? 2'(sel_of(s, k)) : 2'd0;
        v  = e && b && (sl != 2'd3 || dv);
        a  = v && rdy;
        r        = '0;
        r[21]    = v;
        r[20:19] = sl;
        r[18:15] = k[3:0];
        r[14:7]  = s[7:0];
        r[6]     = b && sign_of(s);
        r[5]     = a && (sl == 2'd3);
        r[4]     = a && (sl == 2'd2);
        r[3]     = v && s == 0 && k == 0;
        r[2]     = v && k == N_FFT - 1;
        r[1]     = v && k == N_FFT - 1 && s == NPRE + n - 1;
        r[0]     = b;
        return r;
    endfunction

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            nd = (i == 0) ? 2 : 255;
            st = (i == 0) ? start : start_long;
            if (!res) begin
                m_busy[i] = 0; m_sym[i] = 0; m_k[i] = 0;
                acc_cnt[i] = 0; dreq_cnt[i] = 0; preq_cnt[i] = 0;
                prev_stall[i] = 1'b0;
            end
            av = (i == 0) ? act0 : act1;
            ev = model_out(i, en, data_valid, ready_in);
            chk((i == 0) ? "outputs" : "outputs_long", av, ev);
            if (prev_stall[i] && res) chk("stall_hold", av[20:7], prev_vec[i][20:7]);
            prev_stall[i] = av[21] && !ready_in;
            prev_vec[i]   = av;
            if (av[21] && ready_in && av[14:7] >= NPRE) chk("body_sel", av[20:19], lit_body[av[18:15]]);
            if (av[21] && av[14:7] <= 8) chk("pilot_sign_lit", av[6], lit_sign[av[14:7]]);
            if (av[21] && ready_in) begin
                acc_cnt[i]++;
                dreq_cnt[i] += av[5];
                preq_cnt[i] += av[4];
                if (av[1]) begin
                    chk("frame_accepts", acc_cnt[i], (NPRE + nd) * 16);
                    chk("frame_data_req", dreq_cnt[i], nd * 8);
                    chk("frame_pilot_req", preq_cnt[i], nd * 4);
                    frames[i]++;
                    acc_cnt[i] = 0; dreq_cnt[i] = 0; preq_cnt[i] = 0;
                end
            end
            if (res && en) begin
                if (m_busy[i] == 0) begin
                    if (st) begin m_busy[i] = 1; m_sym[i] = 0; m_k[i] = 0; end
                end else if (ev[21] && ready_in) begin
                    if (m_k[i] == N_FFT - 1) begin
                        m_k[i] = 0;
                        if (m_sym[i] == NPRE + nd - 1) begin
                            m_busy[i] = 0; m_sym[i] = 0;
                        end else begin
                            m_sym[i]++;
                        end
                    end else begin
                        m_k[i]++;
                    end
                end
            end
        end
    end

    function automatic bit hit(int c);
        case (c)
            0:       return valid_out && ready_in && eof;
            1:       return valid_out && sym == 8'd1 && count == 4'd1;
            2:       return valid_out && sym == 8'd2 && count == 4'd5;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int c, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (hit(c)) begin
                done = 1'b1;
            end else begin
                n++;
                if (n >= budget) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wait_%0d: timed out after %0d cycles", c, budget);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_sym[i] = 0; m_k[i] = 0; frames[i] = 0;
            acc_cnt[i] = 0; dreq_cnt[i] = 0; preq_cnt[i] = 0;
            prev_stall[i] = 1'b0; prev_vec[i] = '0;
        end
        res = 1'b0; en = 1'b0; start = 1'b0; start_long = 1'b0;
        ready_in = 1'b0; data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 res = 1'b1;
        @(negedge clk);
        chk("reset_state", act0, 0);
        chk("reset_state_long", act1, 0);

        // Free run
        step();
        en = 1'b1; ready_in = 1'b1; data_valid = 1'b1; start = 1'b1; start_long = 1'b1;
        @(negedge clk);
        chk("sop_before_edge", {sop, busy}, 2'b00);
        step();
        start = 1'b0; start_long = 1'b0;
        @(negedge clk);
        chk("sop_first", {sop, busy, count, sym}, {1'b1, 1'b1, 4'd0, 8'd0});
        chk("pilot_sign_first", pilot_sign, 1);
        wait_until(0, 100);
        @(negedge clk);
        chk("busy_fall", busy, 0);

        // QAM source dries up at the first data slot of symbol 1
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_until(1, 100);
        step();
        data_valid = 1'b0;
        @(negedge clk);
        chk("pilot_not_delayed", {valid_out, sel, count, pilot_req}, {1'b1, 2'd2, 4'd2, 1'b1});
        repeat (5) begin
            @(negedge clk);
            chk("dv_stall", {valid_out, data_req, count}, {1'b0, 1'b0, 4'd3});
        end
        step();
        data_valid = 1'b1;
        wait_until(0, 100);

        // Random backpressure, enable drops and stray starts until the long frame completes
        n = 0;
        while (busy_l && n < 30000) begin
            step();
            ready_in   = ($urandom_range(0, 3) != 0);
            data_valid = ($urandom_range(0, 3) != 0);
            en         = ($urandom_range(0, 7) != 0);
            start      = ($urandom_range(0, 5) == 0);
            n++;
        end
        chk("long_frame_done", frames[1], 1);

        // Start held high: back-to-back frames with one idle cycle
        step();
        en = 1'b1; ready_in = 1'b1; data_valid = 1'b1; start = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_until(0, 200);
            @(negedge clk);
            chk("b2b_idle", {busy, valid_out}, 2'b00);
            @(negedge clk);
            chk("b2b_sop", {busy, sop}, 2'b11);
        end
        step();
        start = 1'b0;

        // Asynchronous reset mid-frame
        wait_until(2, 100);
        #2 res = 1'b0;
        #1 chk("async_reset", act0, 0);
        step();
        step();
        res = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("restart", {sop, busy, sym, count}, {1'b1, 1'b1, 8'd0, 4'd0});
        wait_until(0, 100);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
